// File: rtl/frame_policer.sv
// Ingress frame policer: credit-based forward/discard decision taken once per frame start.
// Credit tracks the egress shaper's slope model and saturates between runtime bounds.
module frame_policer (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] idle_slope,
  input  logic signed [31:0] send_slope,
  input  logic signed [31:0] max_credit,
  input  logic signed [31:0] min_credit,
  output logic signed [31:0] credit,
  output logic [1:0]         state,
  output logic [31:0]        passed_frames,
  output logic [31:0]        dropped_frames,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tuser,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic signed [31:0] credit_q, credit_d;
  logic [31:0]        passed_q, passed_d;
  logic [31:0]        dropped_q, dropped_d;

  logic               fwd;
  logic signed [33:0] credit_x, idle_x, send_x, max_x, min_x, sum;

  // Payload always follows the input; only tvalid qualifies it.
  assign m_axis_tdata   = s_axis_tdata;
  assign m_axis_tlast   = s_axis_tlast;
  assign m_axis_tuser   = s_axis_tuser;

  assign credit         = credit_q;
  assign state          = state_q;
  assign passed_frames  = passed_q;
  assign dropped_frames = dropped_q;

  always_comb begin
    state_d       = state_q;
    passed_d      = passed_q;
    dropped_d     = dropped_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          state_d = credit_q[31] ? StDrop : StPass;
        end
      end
      StPass: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          passed_d = passed_q + 32'd1;
          state_d  = StIdle;
        end
      end
      StDrop: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          dropped_d = dropped_q + 32'd1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // 34-bit sum so that two 32-bit addends can never wrap before the clamp.
  assign fwd      = (state_q == StPass) && s_axis_tvalid && m_axis_tready;
  assign credit_x = {{2{credit_q[31]}}, credit_q};
  assign idle_x   = {{2{idle_slope[31]}}, idle_slope};
  assign send_x   = {{2{send_slope[31]}}, send_slope};
  assign max_x    = {{2{max_credit[31]}}, max_credit};
  assign min_x    = {{2{min_credit[31]}}, min_credit};
  assign sum      = credit_x + idle_x + (fwd ? send_x : 34'sd0);

  always_comb begin
    credit_d = sum[31:0];
    if (sum > max_x) begin
      credit_d = max_credit;
    end else if (sum < min_x) begin
      credit_d = min_credit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      credit_q  <= 32'sd0;
      passed_q  <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      passed_q  <= passed_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_frame_policer.sv
// Directed bench for frame_policer: reset, pass, drop, saturation, backpressure,
// mid-frame reset and a throttled multi-frame stream.
module tb_frame_policer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] idle_slope, send_slope, max_credit, min_credit;
  logic signed [31:0] credit;
  logic [1:0]         state;
  logic [31:0]        passed_frames, dropped_frames;
  logic [7:0]         s_axis_tdata;
  logic               s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;

  int n_checks = 0;
  int n_fail   = 0;

  frame_policer dut (
    .clk            (clk),
    .rst            (rst),
    .idle_slope     (idle_slope),
    .send_slope     (send_slope),
    .max_credit     (max_credit),
    .min_credit     (min_credit),
    .credit         (credit),
    .state          (state),
    .passed_frames  (passed_frames),
    .dropped_frames (dropped_frames),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_slope    = 32'sd1;
    send_slope    = -32'sd1;
    max_credit    = 32'sh7FFFFFFF;
    min_credit    = 32'sh80000000;
    rst           = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h5A;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b1;
    m_axis_tready = 1'b1;
    repeat (10) step();
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b want 0", s_axis_tready); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
    n_checks++; if (credit !== 32'sd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_checks++; if (passed_frames !== 32'd0) begin n_fail++; $display("FAIL reset_passed: got %0d want 0", passed_frames); end
    n_checks++; if (dropped_frames !== 32'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", dropped_frames); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (m_axis_tdata !== 8'h5A || m_axis_tuser !== 1'b1) begin n_fail++; $display("FAIL reset_payload_follow: got %h/%b want 5a/1", m_axis_tdata, m_axis_tuser); end
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic test_pass();
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h01;
    m_axis_tready = 1'b1;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL pass_idle_latency: got tvalid %b tready %b want 0 0", m_axis_tvalid, s_axis_tready); end
    step();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL pass_state: got %0d want 1", state); end
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = 8'(i + 1);
      s_axis_tlast = (i == 3);
      #1;
      n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(i + 1) || m_axis_tlast !== (i == 3)) begin
        n_fail++; $display("FAIL pass_beat%0d: got v%b d%h l%b want v1 d%h l%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 8'(i + 1), (i == 3));
      end
      n_checks++; if (credit !== 32'sd1) begin n_fail++; $display("FAIL pass_credit_beat%0d: got %0d want 1", i, credit); end
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++; if (passed_frames !== 32'd1) begin n_fail++; $display("FAIL pass_count: got %0d want 1", passed_frames); end
    n_checks++; if (state !== 2'd0 || credit !== 32'sd1) begin n_fail++; $display("FAIL pass_end: got state %0d credit %0d want 0 1", state, credit); end
  endtask

  task automatic test_drop();
    do_reset();
    send_slope    = -32'sd10;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h10;
    m_axis_tready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = 8'(8'h10 + i);
      s_axis_tlast = (i == 3);
      step();
    end
    n_checks++; if (credit !== -32'sd35 || passed_frames !== 32'd1 || state !== 2'd0) begin
      n_fail++; $display("FAIL drop_first_frame: got credit %0d passed %0d state %0d want -35 1 0", credit, passed_frames, state);
    end
    // Second frame arrives back to back; its first beat must wait out the IDLE gap.
    s_axis_tdata = 8'h20;
    s_axis_tlast = 1'b0;
    #1;
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL drop_gap_tready: got %b want 0", s_axis_tready); end
    step();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL drop_state: got %0d want 2", state); end
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = 8'(8'h20 + i);
      s_axis_tlast = (i == 3);
      #1;
      n_checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
        n_fail++; $display("FAIL drop_beat%0d: got m_tvalid %b s_tready %b want 0 1", i, m_axis_tvalid, s_axis_tready);
      end
      n_checks++; if (credit !== -32'sd34 + i) begin n_fail++; $display("FAIL drop_credit_beat%0d: got %0d want %0d", i, credit, -34 + i); end
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++; if (dropped_frames !== 32'd1 || passed_frames !== 32'd1 || state !== 2'd0) begin
      n_fail++; $display("FAIL drop_counts: got dropped %0d passed %0d state %0d want 1 1 0", dropped_frames, passed_frames, state);
    end
    n_checks++; if (credit !== -32'sd30) begin n_fail++; $display("FAIL drop_credit_end: got %0d want -30", credit); end
    step();
    n_checks++; if (credit !== -32'sd29) begin n_fail++; $display("FAIL drop_credit_rise1: got %0d want -29", credit); end
    step();
    n_checks++; if (credit !== -32'sd28) begin n_fail++; $display("FAIL drop_credit_rise2: got %0d want -28", credit); end
    send_slope = -32'sd1;
  endtask

  task automatic test_saturation();
    do_reset();
    max_credit = 32'sd5;
    repeat (100) step();
    n_checks++; if (credit !== 32'sd5) begin n_fail++; $display("FAIL sat_max: got %0d want 5", credit); end
    min_credit    = -32'sd20;
    send_slope    = -32'sd100;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    s_axis_tdata  = 8'h77;
    m_axis_tready = 1'b1;
    step();
    n_checks++; if (state !== 2'd1 || credit !== 32'sd5) begin n_fail++; $display("FAIL sat_single_enter: got state %0d credit %0d want 1 5", state, credit); end
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++; if (state !== 2'd0 || passed_frames !== 32'd1) begin n_fail++; $display("FAIL sat_single_exit: got state %0d passed %0d want 0 1", state, passed_frames); end
    n_checks++; if (credit !== -32'sd20) begin n_fail++; $display("FAIL sat_min: got %0d want -20", credit); end
    step();
    n_checks++; if (credit !== -32'sd19) begin n_fail++; $display("FAIL sat_min_rise: got %0d want -19", credit); end
    // Large idle slope: second add would wrap in 32 bits but must clamp to max.
    idle_slope = 32'sh7FFFFFFF;
    max_credit = 32'sh7FFFFFFF;
    step();
    n_checks++; if (credit !== 32'sh7FFFFFEC) begin n_fail++; $display("FAIL sat_big_add: got %h want 7fffffec", credit); end
    step();
    n_checks++; if (credit !== 32'sh7FFFFFFF) begin n_fail++; $display("FAIL sat_overflow_clamp: got %h want 7fffffff", credit); end
    idle_slope = 32'sd1;
    send_slope = -32'sd1;
    min_credit = 32'sh80000000;
  endtask

  task automatic test_backpressure();
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hAA;
    m_axis_tready = 1'b1;
    step();
    n_checks++; if (m_axis_tdata !== 8'hAA || m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got d%h v%b want aa 1", m_axis_tdata, m_axis_tvalid); end
    step();
    s_axis_tdata  = 8'hBB;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
        n_fail++; $display("FAIL bp_stall%0d: got s_tready %b m_tvalid %b want 0 1", i, s_axis_tready, m_axis_tvalid);
      end
      step();
    end
    n_checks++; if (credit !== 32'sd21 || state !== 2'd1) begin n_fail++; $display("FAIL bp_stall_credit: got %0d state %0d want 21 1", credit, state); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = 8'(8'hBB + 8'h11 * i);
      s_axis_tlast = (i == 2);
      #1;
      n_checks++; if (m_axis_tdata !== 8'(8'hBB + 8'h11 * i) || m_axis_tvalid !== 1'b1 || credit !== 32'sd21) begin
        n_fail++; $display("FAIL bp_resume%0d: got d%h v%b credit %0d want d%h v1 21", i, m_axis_tdata, m_axis_tvalid, credit, 8'(8'hBB + 8'h11 * i));
      end
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++; if (passed_frames !== 32'd1 || state !== 2'd0) begin n_fail++; $display("FAIL bp_end: got passed %0d state %0d want 1 0", passed_frames, state); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h31;
    m_axis_tready = 1'b1;
    idle_slope    = 32'sd3;
    step();
    step();
    s_axis_tdata = 8'h32;
    rst          = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (state !== 2'd0 || credit !== 32'sd0 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: got state %0d credit %0d m_tvalid %b want 0 0 0", state, credit, m_axis_tvalid);
    end
    step();
    n_checks++; if (state !== 2'd1 || m_axis_tdata !== 8'h32) begin n_fail++; $display("FAIL midrst_restart: got state %0d d%h want 1 32", state, m_axis_tdata); end
    s_axis_tlast = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    idle_slope    = 32'sd1;
    n_checks++; if (passed_frames !== 32'd1 || state !== 2'd0) begin n_fail++; $display("FAIL midrst_end: got passed %0d state %0d want 1 0", passed_frames, state); end
  endtask

  task automatic test_stream();
    logic [7:0] src_d[9];
    logic       src_l[9];
    logic [7:0] got_d[9];
    logic       got_l[9];
    int         lens[3];
    int         k, si, got;
    logic       hs;
    lens = '{3, 1, 5};
    k = 0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < lens[f]; b++) begin
        src_d[k] = 8'(8'h40 + k);
        src_l[k] = (b == lens[f] - 1);
        k++;
      end
    end
    do_reset();
    si  = 0;
    got = 0;
    for (int cyc = 0; cyc < 300 && got < 9; cyc++) begin
      if (!s_axis_tvalid) s_axis_tvalid = (si < 9) && (cyc % 3 != 2);
      if (si < 9) begin
        s_axis_tdata = src_d[si];
        s_axis_tlast = src_l[si];
      end
      m_axis_tready = (cyc % 4 != 1);
      #1;
      if (m_axis_tvalid && m_axis_tready && got < 9) begin
        got_d[got] = m_axis_tdata;
        got_l[got] = m_axis_tlast;
        got++;
      end
      hs = s_axis_tvalid && s_axis_tready;
      if (hs) si++;
      step();
      if (hs) s_axis_tvalid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++; if (got !== 9) begin n_fail++; $display("FAIL stream_beats: got %0d want 9 (cycle budget)", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (got_d[i] !== src_d[i] || got_l[i] !== src_l[i]) begin
        n_fail++; $display("FAIL stream_beat%0d: got d%h l%b want d%h l%b", i, got_d[i], got_l[i], src_d[i], src_l[i]);
      end
    end
    step();
    n_checks++; if (passed_frames !== 32'd3 || dropped_frames !== 32'd0) begin
      n_fail++; $display("FAIL stream_counts: got passed %0d dropped %0d want 3 0", passed_frames, dropped_frames);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_drop();
    test_saturation();
    test_backpressure();
    test_reset_mid_frame();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_policer.md
# frame_policer

- Ingress-side counterpart of `credit_based_shaper`.
- Polices an 8-bit AXI4-Stream frame flow with a saturating signed credit counter.
- At each frame start it decides, from the current credit, whether to forward the whole frame or discard it. Frames are never truncated.
- Sits between the receive MAC stream and the switch core and uses the same idle/send slope and credit-limit settings as the shaper.

## Interface
Parameters: none. Settings are runtime ports.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `idle_slope`  in  32 signed  credit added every cycle; expected positive.
- `send_slope`  in  32 signed  credit added per forwarded byte; expected negative.
- `max_credit`  in  32 signed  upper saturation bound.
- `min_credit`  in  32 signed  lower saturation bound.
- `credit`  out  32 signed  current credit (debug).
- `state`  out  2  FSM state: 0 IDLE, 1 PASS, 2 DROP.
- `passed_frames`  out  32  count of forwarded frames, wraps.
- `dropped_frames`  out  32  count of discarded frames, wraps.
- `s_axis_tdata`/`tvalid`/`tready`/`tlast`/`tuser`  in/in/out/in/in  8/1/1/1/1  input stream.
- `m_axis_tdata`/`tvalid`/`tready`/`tlast`/`tuser`  out/out/in/out/out  8/1/1/1/1  output stream.

## Operation
FSM states:
- IDLE:
  - `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - When `s_axis_tvalid`=1, go to PASS if `credit` >= 0, else DROP.
  - The decision is registered and no beat is consumed in IDLE.
- PASS:
  - Combinational pass-through: `m_axis_tvalid`=`s_axis_tvalid`, `s_axis_tready`=`m_axis_tready`, and tdata/tlast/tuser are copied.
  - On the handshake with tlast=1: `passed_frames`++ and go to IDLE.
- DROP:
  - `s_axis_tready`=1 and `m_axis_tvalid`=0; beats are consumed and discarded.
  - On the handshake with tlast=1: `dropped_frames`++ and go to IDLE.

Credit update, every cycle:
- `fwd` = (state==PASS && `s_axis_tvalid` && `m_axis_tready`).
- sum = credit + idle_slope + (fwd ? send_slope : 0), computed sign-extended in 34 bits.
- New credit = clamp(sum, min_credit, max_credit). If sum > max_credit it becomes max_credit; if sum < min_credit it becomes min_credit.
- Dropped beats and stalled cycles add only idle_slope.
- Bound changes take effect through the clamp on the next update.
- If min_credit > max_credit, the behaviour is unspecified.

Boundary conditions:
- `credit` == 0 at a frame start: the frame is passed.
- Frame consisting of a single beat with tlast=1: PASS or DROP lasts exactly one handshake, then returns to IDLE.
- Reset mid-frame: the FSM returns to IDLE and any remaining beats are treated as a new frame start. Upstream shares `rst`.
- Counters wrap 0xFFFFFFFF -> 0.

## Timing
- Reset values:
  - `credit`=0, `state`=IDLE, both counters=0.
  - `s_axis_tready`=0, `m_axis_tvalid`=0.
  - `m_axis_tdata`/`tlast`/`tuser` follow the input but are qualified invalid.
- Decision latency: the first beat is forwarded no earlier than 1 cycle after `s_axis_tvalid` rises in IDLE.
- Within PASS the latency is 0 cycles (combinational).
- Inter-frame gap: minimum 1 cycle in IDLE after each tlast handshake, even if the next tvalid is already high. The decision for the next frame uses credit including the tlast-cycle update.
- No combinational path from `m_axis_tready` to `m_axis_tvalid`.

## Test plan
1. **Reset:** hold `rst`=1 for 10 cycles with `s_axis_tvalid`=1.
   - `s_axis_tready`=0, `m_axis_tvalid`=0, `credit`=0, counters=0.
2. **Pass:** idle_slope=1, send_slope=-1, max=0x7FFFFFFF, min=0x80000000; after reset send a 4-byte frame 01 02 03 04 with `m_axis_tready`=1.
   - Output 01 02 03 04, tlast on 04, `passed_frames`=1.
   - Credit unchanged during the 4 forwarded beats.
3. **Drop:** send_slope=-10, idle_slope=1; send two back-to-back 4-byte frames, the first at credit=0.
   - First frame passed; credit goes to -36 plus idle cycles.
   - Second frame dropped: `m_axis_tvalid` stays 0, `s_axis_tready`=1 for all 4 beats, `dropped_frames`=1.
   - Credit then rises by 1 per cycle.
4. **Saturation:** max_credit=5; idle 100 cycles -> credit=5.
   - Then min_credit=-20, send_slope=-100; forward 1 byte -> credit=-20.
5. **Backpressure:** `m_axis_tready`=0 for 20 cycles mid-frame in PASS.
   - `s_axis_tready`=0 and no beat is lost.
   - Credit +20 over the stall; the frame completes intact once `m_axis_tready`=1.
6. **Stream check:** pcap-driven stream with `M_AXIS_TVALID_OUT_CYCLE`/`S_AXIS_TREADY_OUT_CYCLE` throttling and idle=1, send=-1.
   - All frames match the pcap.
   - `passed_frames` equals the number of frames in the pcap.
